// File: rtl/bus_host_link_pkg.sv
// bus_host_link_pkg: frame constants, command codes and FSM states shared by the serial host link.
package bus_host_link_pkg;
    localparam int FRAME_W = 12;
    localparam int CMD_FLAG = 8;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ = 8'h02;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAITRESP, DONE} state_t;

    // start bit, command flag, byte, two zero stop bits
    function automatic logic [FRAME_W-1:0] frame(input logic cmd, input logic [7:0] b);
        return {1'b1, cmd, b, 2'b00};
    endfunction
endpackage

// File: rtl/bus_rx_frame.sv
// bus_rx_frame: continuous 12-bit frame deserialiser; pulses byte_valid during the second stop bit.
module bus_rx_frame (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       byte_valid,
    output logic [8:0] data,
    output logic       frame_err
);
    logic [3:0] cnt;
    logic       stop1;

    // cnt 0 hunts for a start bit, 1..9 carry b8..b0, 10..11 the stop bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            data <= 9'd0;
            stop1 <= 1'b0;
        end else begin
            cnt <= cnt == 4'd0 ? {3'd0, rx_serial} : cnt == 4'd11 ? 4'd0 : cnt + 4'd1;
            if (cnt >= 4'd1 && cnt <= 4'd9) data <= {data[7:0], rx_serial};
            if (cnt == 4'd10) stop1 <= rx_serial;
        end
    end

    assign byte_valid = cnt == 4'd11;
    assign frame_err = byte_valid & (stop1 | rx_serial);
endmodule

// File: rtl/bus_host_link.sv
// bus_host_link: turns one register request into a framed serial message and
// matches the serial reply into an ack, read data or error, with a timeout.
module bus_host_link
    import bus_host_link_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TOW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wrdata,
    output logic        resp_valid,
    output logic [15:0] resp_rddata,
    output logic        resp_err,
    output logic        busy,
    output logic        tx_serial,
    input  logic        rx_serial
);
    state_t state, next;
    logic wr_q;
    logic [15:0] addr_q, wd_q, rdbuf;
    logic [59:0] msg, sr;
    logic [5:0] cnt;
    logic [TOW-1:0] tcnt;
    logic [1:0] ridx;
    logic byte_valid, frame_err, fin, fin_ok;
    logic [8:0] rx_byte;

    bus_rx_frame u_rx (
        .clk(clk),
        .rst(rst),
        .rx_serial(rx_serial),
        .byte_valid(byte_valid),
        .data(rx_byte),
        .frame_err(frame_err)
    );

    assign req_ready = state == IDLE && !rst;
    assign busy = state != IDLE;
    assign resp_valid = state == DONE;
    assign msg = wr_q
        ? {frame(1'b0, wd_q[15:8]), frame(1'b0, wd_q[7:0]), frame(1'b0, addr_q[15:8]),
           frame(1'b0, addr_q[7:0]), frame(1'b1, CMD_WRITE)}
        : {frame(1'b0, addr_q[15:8]), frame(1'b0, addr_q[7:0]), frame(1'b1, CMD_READ), 24'd0};

    always_comb begin
        next = state;
        fin = 1'b0;
        fin_ok = 1'b0;
        case (state)
            IDLE: next = req_valid ? LOAD : IDLE;
            LOAD: next = SHIFT;
            SHIFT: next = cnt == 6'd0 ? WAITRESP : SHIFT;
            WAITRESP: begin
                // a completed byte takes priority over an expiring timeout
                if (byte_valid) begin
                    fin = frame_err | wr_q | ridx == 2'd2 | rx_byte[CMD_FLAG];
                    fin_ok = !frame_err & (wr_q | ridx == 2'd2)
                           & (rx_byte == {1'b1, wr_q ? CMD_WRITE : CMD_READ});
                end else fin = tcnt == TOW'(TIMEOUT);
                next = fin ? DONE : WAITRESP;
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wr_q <= 1'b0;
            addr_q <= 16'd0;
            wd_q <= 16'd0;
            rdbuf <= 16'd0;
            sr <= 60'd0;
            cnt <= 6'd0;
            tcnt <= '0;
            ridx <= 2'd0;
            tx_serial <= 1'b0;
            resp_rddata <= 16'd0;
            resp_err <= 1'b0;
        end else begin
            state <= next;
            case (state)
                IDLE: if (req_valid) begin
                    wr_q <= req_write;
                    addr_q <= req_addr;
                    wd_q <= req_wrdata;
                    tx_serial <= 1'b1;
                end
                // start bit already went out at accept; LOAD emits bit 1
                LOAD: begin
                    sr <= msg << 2;
                    tx_serial <= msg[58];
                    cnt <= wr_q ? 6'd58 : 6'd34;
                    tcnt <= '0;
                    ridx <= 2'd0;
                    rdbuf <= 16'd0;
                end
                SHIFT: begin
                    tx_serial <= cnt != 6'd0 && sr[59];
                    sr <= sr << 1;
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                WAITRESP: begin
                    tcnt <= tcnt + TOW'(1);
                    if (byte_valid && !fin) begin
                        rdbuf <= ridx == 2'd0 ? {rx_byte[7:0], rdbuf[7:0]} : {rdbuf[15:8], rx_byte[7:0]};
                        ridx <= ridx + 2'd1;
                    end
                    if (fin) begin
                        resp_rddata <= fin_ok && !wr_q ? rdbuf : 16'd0;
                        resp_err <= !fin_ok;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_host_link.sv
// tb_bus_host_link: directed bench with a behavioural bus FSM model (breg at 0x1234,
// read-only 0xA5C3 at 0x0042) that decodes tx_serial and replies on rx_serial.
module tb_bus_host_link;
    localparam int TO = 40;

    logic clk, rst, req_valid, req_ready, req_write, resp_valid, resp_err, busy, tx_serial, rx_serial;
    logic [15:0] req_addr, req_wrdata, resp_rddata;
    int checks = 0, errors = 0, cyc = 0;

    bus_host_link #(.TIMEOUT(TO), .TOW(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wrdata(req_wrdata),
        .resp_valid(resp_valid), .resp_rddata(resp_rddata), .resp_err(resp_err),
        .busy(busy), .tx_serial(tx_serial), .rx_serial(rx_serial)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // reply modes: 0 normal, 1 silent, 2 answer a read with 0x101, 3 bad stop bit
    int mode = 0, fcnt = 0, nd = 0, t_first = 0, t_end = 0, msg_len = 0, t_resp = 0;
    logic [11:0] fr;
    logic [8:0] b;
    logic [31:0] d;
    logic [15:0] breg, mrd;

    task automatic send(input logic [8:0] v, input logic bad);
        logic [11:0] f;
        f = {1'b1, v, bad, 1'b0};
        for (int i = 11; i >= 0; i--) begin
            rx_serial = f[i];
            @(negedge clk);
        end
        rx_serial = 1'b0;
    endtask

    initial begin
        rx_serial = 0;
        breg = 0;
        d = 0;
        fr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fcnt = 0;
                nd = 0;
                breg = 0;
            end else if (fcnt == 0) begin
                if (tx_serial) begin
                    fcnt = 1;
                    fr = 12'd1;
                    if (nd == 0) t_first = cyc;
                end
            end else begin
                fr = {fr[10:0], tx_serial};
                fcnt++;
                if (fcnt == 12) begin
                    fcnt = 0;
                    b = fr[10:2];
                    if (!b[8]) begin
                        d = {d[23:0], b[7:0]};
                        nd++;
                    end else begin
                        t_end = cyc;
                        msg_len = t_end - t_first + 1;
                        if (b == 9'h101 && nd == 4) begin
                            if (d[15:0] == 16'h1234) breg = d[31:16];
                            if (mode != 1) send(9'h101, 1'b0);
                        end else if (b == 9'h102 && nd == 2) begin
                            mrd = d[15:0] == 16'h1234 ? breg : d[15:0] == 16'h0042 ? 16'hA5C3 : 16'h0000;
                            if (mode == 0) begin
                                send({1'b0, mrd[15:8]}, 1'b0);
                                send({1'b0, mrd[7:0]}, 1'b0);
                                send(9'h102, 1'b0);
                            end else if (mode == 2) send(9'h101, 1'b0);
                            else if (mode == 3) send({1'b0, mrd[15:8]}, 1'b1);
                        end
                        nd = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] wd);
        @(negedge clk);
        req_write = w;
        req_addr = a;
        req_wrdata = wd;
        req_valid = 1;
        check("issue_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic wait_resp(output logic [15:0] rd, output logic er);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        t_resp = cyc;
        check("resp_seen", resp_valid, 1);
        rd = resp_rddata;
        er = resp_err;
        @(negedge clk);
        check("resp_pulse_1cyc", resp_valid, 0);
    endtask

    logic [11:0] v;
    logic [15:0] rd;
    logic er, flag;
    int n;

    initial begin
        rst = 1;
        req_valid = 0;
        req_write = 0;
        req_addr = 0;
        req_wrdata = 0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_serial, 0);
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rddata", resp_rddata, 0);
        check("rst_err", resp_err, 0);
        rst = 0;
        @(negedge clk);
        check("idle_ready", req_ready, 1);

        issue(1, 16'h1234, 16'hBEEF);
        v = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            v = {v[10:0], tx_serial};
        end
        check("wr_frame0", v, {1'b1, 9'h0BE, 2'b00});
        wait_resp(rd, er);
        check("wr_err", er, 0);
        check("wr_rddata", rd, 0);
        check("wr_tx_len", msg_len, 60);
        check("wr_breg", breg, 16'hBEEF);

        issue(0, 16'h0042, 16'h0);
        wait_resp(rd, er);
        check("rd_data", rd, 16'hA5C3);
        check("rd_err", er, 0);
        check("rd_tx_len", msg_len, 36);

        mode = 1;
        issue(0, 16'h0042, 16'h0);
        wait_resp(rd, er);
        check("to_err", er, 1);
        check("to_rddata", rd, 0);
        // WAITRESP lasts TIMEOUT+1 cycles between the last stop bit and DONE
        check("to_gap", t_resp - t_end - 1, TO + 1);

        mode = 2;
        issue(0, 16'h0042, 16'h0);
        wait_resp(rd, er);
        check("unexp_err", er, 1);
        check("unexp_rddata", rd, 0);

        mode = 3;
        issue(0, 16'h0042, 16'h0);
        wait_resp(rd, er);
        check("stop_err", er, 1);
        check("stop_rddata", rd, 0);

        mode = 0;
        @(negedge clk);
        req_write = 1;
        req_addr = 16'h1234;
        req_wrdata = 16'h5A5A;
        req_valid = 1;
        @(posedge clk);
        #1 req_write = 0;
        req_wrdata = 0;
        flag = 0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 300) begin
            flag |= req_ready;
            @(negedge clk);
            n++;
        end
        flag |= req_ready;
        check("b2b_resp1", resp_valid, 1);
        check("b2b_err1", resp_err, 0);
        check("b2b_rddata1", resp_rddata, 0);
        check("b2b_ready_low", flag, 0);
        @(negedge clk);
        check("b2b_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        check("b2b_busy2", busy, 1);
        wait_resp(rd, er);
        check("b2b_rddata2", rd, 16'h5A5A);
        check("b2b_err2", er, 0);

        issue(1, 16'h1234, 16'h1111);
        for (int i = 0; i < 30; i++) @(negedge clk);
        check("rst_mid_tx_pre", tx_serial, 1);
        rst = 1;
        #1;
        check("rst_mid_tx", tx_serial, 0);
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_busy", busy, 0);
        flag = 0;
        repeat (3) @(negedge clk) flag |= resp_valid;
        rst = 0;
        #1;
        check("rst_rel_ready", req_ready, 1);
        repeat (20) @(negedge clk) flag |= resp_valid;
        check("rst_no_resp", flag, 0);
        issue(0, 16'h1234, 16'h0);
        wait_resp(rd, er);
        check("rst_rd_data", rd, 0);
        check("rst_rd_err", er, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
